// File: rtl/i2c_arb_pkg.sv
// Shared types and constants for the I2C transaction arbiter.
package i2c_arb_pkg;

    localparam int I2C_ADDR_W = 7;
    localparam int I2C_DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        ARB,
        ISSUE,
        WAIT,
        RESP
    } arb_state_t;

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_NACK    = 2'b01;
    localparam logic [1:0] ST_TIMEOUT = 2'b10;

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first set request at or above ptr, with wrap-around.
module rr_priority_picker #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         gnt_onehot,
    output logic [$clog2(N)-1:0] gnt_idx,
    output logic                 any
);

    localparam int IW = $clog2(N);

    logic [IW-1:0] cand;

    // Walk the rotated order backwards so the candidate closest to ptr is written last and wins.
    always_comb begin
        gnt_onehot = '0;
        gnt_idx    = '0;
        any        = 1'b0;
        cand       = '0;
        for (int k = N - 1; k >= 0; k--) begin
            cand = IW'((int'(ptr) + k) % N);
            if (req[cand]) begin
                gnt_onehot       = '0;
                gnt_onehot[cand] = 1'b1;
                gnt_idx          = cand;
                any              = 1'b1;
            end
        end
    end

endmodule

// File: rtl/i2c_txn_arbiter.sv
// Shares one I2C master among NUM_REQ requesters: round-robin grant, command issue,
// completion/watchdog handling and per-requester response.
module i2c_txn_arbiter
    import i2c_arb_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [I2C_ADDR_W*NUM_REQ-1:0] req_addr,
    input  logic [NUM_REQ-1:0]            req_rw,
    input  logic [I2C_DATA_W*NUM_REQ-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [I2C_DATA_W-1:0]         rsp_rdata,
    output logic [1:0]                    rsp_status,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          m_start,
    output logic [I2C_ADDR_W-1:0]         m_addr,
    output logic                          m_rw,
    output logic [I2C_DATA_W-1:0]         m_wdata,
    output logic                          m_abort,
    input  logic                          m_busy,
    input  logic                          m_done,
    input  logic [I2C_DATA_W-1:0]         m_rdata,
    input  logic                          m_ack_error
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

    arb_state_t         state;
    logic [IDX_W-1:0]   rr_ptr;
    logic [TMR_W-1:0]   timer;
    logic [NUM_REQ-1:0] pick_onehot;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;

    rr_priority_picker #(.N(NUM_REQ)) u_picker (
        .req        (req_valid),
        .ptr        (rr_ptr),
        .gnt_onehot (pick_onehot),
        .gnt_idx    (pick_idx),
        .any        (pick_any)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            timer      <= '0;
            req_ready  <= '0;
            rsp_valid  <= '0;
            rsp_rdata  <= '0;
            rsp_status <= ST_OK;
            grant_id   <= '0;
            m_start    <= 1'b0;
            m_addr     <= '0;
            m_rw       <= 1'b0;
            m_wdata    <= '0;
            m_abort    <= 1'b0;
        end else begin
            req_ready <= '0;
            rsp_valid <= '0;
            m_start   <= 1'b0;
            m_abort   <= 1'b0;
            case (state)
                IDLE: begin
                    if (|req_valid) state <= ARB;
                end
                ARB: begin
                    if (pick_any) begin
                        req_ready <= pick_onehot;
                        m_addr    <= req_addr[32'(pick_idx)*I2C_ADDR_W +: I2C_ADDR_W];
                        m_rw      <= req_rw[pick_idx];
                        m_wdata   <= req_wdata[32'(pick_idx)*I2C_DATA_W +: I2C_DATA_W];
                        grant_id  <= pick_idx;
                        state     <= ISSUE;
                    end else begin
                        state <= IDLE;
                    end
                end
                ISSUE: begin
                    if (!m_busy) begin
                        m_start <= 1'b1;
                        timer   <= '0;
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    timer <= timer + 1'b1;
                    // A completion is answered immediately; a timeout first spends a cycle on the abort.
                    if (m_done) begin
                        rsp_valid[grant_id] <= 1'b1;
                        rsp_status          <= m_ack_error ? ST_NACK : ST_OK;
                        rsp_rdata           <= (m_ack_error || !m_rw) ? '0 : m_rdata;
                        state               <= RESP;
                    end else if (timer == TMR_LAST) begin
                        m_abort    <= 1'b1;
                        rsp_status <= ST_TIMEOUT;
                        rsp_rdata  <= '0;
                        state      <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_status == ST_TIMEOUT) rsp_valid[grant_id] <= 1'b1;
                    rr_ptr <= (grant_id == IDX_LAST) ? '0 : grant_id + 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
